fetch_pc_unit: RTL
==================

Name: fetch_pc_unit

Overview:
Owns the program counter and instruction fetch. It issues word fetches to instruction memory over a req/ack handshake and presents the fetched instruction to decode. It drives nextPC (PC+4) into the branch resolution logic, then takes the resolved nextAddr back when the datapath signals instruction completion. It also provides halt, misalignment fault, fetch-timeout fault and a retired-instruction counter.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
TIMEOUT, 16, max cycles waiting for imem_ack before fault; must be >= 1.
CNT_W, 32, width of retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
imem_req  output  1  fetch request, held until ack.
imem_addr  output  32  fetch address (= pc).
imem_ack  input  1  memory returns imem_rdata this cycle.
imem_rdata  input  32  fetched instruction word.
instr  output  32  latched instruction for decode.
instr_valid  output  1  instr holds a live instruction.
pc  output  32  address of current instruction.
nextPC  output  32  pc + 4, combinational, sent to branch resolution.
nextAddr  input  32  resolved next address from branch resolution.
exec_done  input  1  datapath finished current instruction; nextAddr final.
halt_req  input  1  current instruction is halt; sampled with exec_done.
halted  output  1  core stopped.
fault  output  1  stopped due to misaligned target or fetch timeout.
retired  output  CNT_W  count of completed non-halt instructions.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: pc=RESET_PC, state=S_FETCH, imem_req=0 during reset, instr=0, instr_valid=0, halted=0, fault=0, retired=0, timeout counter=0.
- imem_req is decoded from state (S_FETCH); it rises the first cycle after rst deasserts.
- States: S_FETCH, S_EXEC, S_HALT.
- S_FETCH:
  - imem_req=1, imem_addr=pc, timeout counter increments each cycle without ack.
  - On imem_ack: instr<=imem_rdata, instr_valid<=1, counter<=0, go S_EXEC.
  - If counter reaches TIMEOUT-1 without ack: fault<=1, halted<=1, go S_HALT.
  - An ack in the same cycle as expiry wins: the instruction is accepted.
- S_EXEC:
  - instr_valid=1, imem_req=0; wait for exec_done with no limit.
  - On exec_done with halt_req=1: instr_valid<=0, halted<=1, pc unchanged, retired unchanged, go S_HALT.
  - On exec_done with halt_req=0 and nextAddr[1:0]==0: pc<=nextAddr, retired<=retired+1, instr_valid<=0, go S_FETCH.
  - On exec_done with halt_req=0 and nextAddr[1:0]!=0: retired+1, pc unchanged, fault<=1, halted<=1, instr_valid<=0, go S_HALT.
- S_HALT: absorbing until rst; all inputs ignored; imem_req=0.
- Inputs outside their states are ignored: exec_done/halt_req outside S_EXEC, imem_ack outside S_FETCH.
- Fetch-to-valid latency: instr_valid rises on the clock edge that samples imem_ack. Minimum 2 cycles per instruction (fetch with same-cycle ack, then exec with same-cycle exec_done).
- Arithmetic: nextPC = pc + 32'd4, modulo 2^32, so 0xFFFF_FFFC wraps to 0x0000_0000. retired wraps modulo 2^CNT_W.
- Reset mid-operation: outstanding request is abandoned and imem_req drops immediately (asynchronously). Memory must tolerate a dropped request.

Decomposition:
- Shared package: state encoding (S_FETCH=2'd0, S_EXEC=2'd1, S_HALT=2'd2), INSTR_W=32, PC_INC=4.
- One sub-module: fetch_timer (loadable up-counter with terminal-count flag, parameter TIMEOUT).
- The FSM, pc register and counter stay in the top module.

Test Plan:
- Reset release, ack same cycle as req with rdata=0x1234_5678, exec_done with nextAddr=nextPC -> imem_addr=0x0, instr=0x1234_5678, pc=0x4 and retired=1 after 2 cycles.
- Branch: exec_done with nextAddr=0x0000_0100 -> next imem_addr=0x100, nextPC=0x104.
- Misaligned: nextAddr=0x0000_0102 -> fault=1, halted=1, pc unchanged, retired incremented, imem_req stays 0.
- Timeout=16 with imem_ack held low -> fault=1, halted=1 on the 16th cycle of S_FETCH; ack on that same cycle -> no fault, instr_valid=1.
- pc=0xFFFF_FFFC -> nextPC=0x0000_0000; exec_done with that nextAddr -> fetch from 0x0.
- halt_req with exec_done -> halted=1, fault=0, retired unchanged. Assert rst mid-S_FETCH -> imem_req=0 immediately, pc=RESET_PC.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch / program-counter unit: FSM state encoding,
// instruction width, PC increment and an alignment helper.
package fetch_pc_unit_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam int          INSTR_W = 32;
    localparam logic [31:0] PC_INC  = 32'd4;

    // A target is a legal fetch address only when it is word aligned.
    function automatic logic is_word_aligned(input logic [1:0] addr_lsbs);
        return (addr_lsbs == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_pc_unit_timer.sv
// Fetch timeout timer: up-counter cleared to zero on demand, raising a
// terminal-count flag once TIMEOUT-1 un-acknowledged cycles have elapsed.
module fetch_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int            CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    // Count waiting cycles; hold at terminal count so the value never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && !o_tc) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction fetch unit. Fetches a word over a req/ack
// handshake, holds it for decode, then advances to the resolved next address
// once the datapath completes. Stops on halt, misaligned target or timeout.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16,
    parameter int          CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [31:0]        pc,
    output logic [31:0]        nextPC,
    input  logic [31:0]        nextAddr,
    input  logic               exec_done,
    input  logic               halt_req,
    output logic               halted,
    output logic               fault,
    output logic [CNT_W-1:0]   retired
);

    state_t             r_state;
    logic [31:0]        r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic               r_instr_valid;
    logic               r_halted;
    logic               r_fault;
    logic [CNT_W-1:0]   r_retired;

    logic w_fetching;
    logic w_tmr_clr;
    logic w_tmr_tc;

    assign w_fetching = (r_state == S_FETCH);

    // Timer only runs while a request is outstanding; any other state or an
    // ack returns it to zero so each fetch gets the full window.
    assign w_tmr_clr = !w_fetching || imem_ack;

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_tmr_clr),
        .i_en  (w_fetching),
        .o_tc  (w_tmr_tc)
    );

    // Main control FSM with pc, instruction latch and retired counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
            r_fault       <= 1'b0;
            r_retired     <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    // An ack arriving on the expiry cycle still wins.
                    if (imem_ack) begin
                        r_instr       <= imem_rdata;
                        r_instr_valid <= 1'b1;
                        r_state       <= S_EXEC;
                    end else if (w_tmr_tc) begin
                        r_fault  <= 1'b1;
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        r_instr_valid <= 1'b0;
                        if (halt_req) begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end else begin
                            // The instruction itself completed, so it retires
                            // even when its branch target turns out misaligned.
                            r_retired <= r_retired + CNT_W'(1);
                            if (is_word_aligned(nextAddr[1:0])) begin
                                r_pc    <= nextAddr;
                                r_state <= S_FETCH;
                            end else begin
                                r_fault  <= 1'b1;
                                r_halted <= 1'b1;
                                r_state  <= S_HALT;
                            end
                        end
                    end
                end
                S_HALT: begin
                end
                default: begin
                    r_state <= S_HALT;
                end
            endcase
        end
    end

    // Gating with rst drops the request the moment reset asserts and keeps it
    // low for the whole reset period even though the state is S_FETCH.
    assign imem_req    = w_fetching && !rst;
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign nextPC      = r_pc + PC_INC;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign halted      = r_halted;
    assign fault       = r_fault;
    assign retired     = r_retired;

endmodule
